// File: rtl/multi_reg_sequencer.sv
// Register-file-side sequencer for LM/SM/LA/SA: one register transfer per slot, lockstep with the address generator.
// Optional MULTI_SEQ_XFER_COUNT_EN adds a 4-bit xfer_count output counting strobes of the last instruction.
module multi_reg_sequencer #(
  parameter int DATA_W = 16,
  parameter int SLOTS  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [3:0]        instr_mem_4,
  input  logic [6:0]        immediate_7,
  input  logic [DATA_W-1:0] data_from_mem_16,
  input  logic [DATA_W-1:0] reg_read_16,
  output logic [2:0]        rf_rd_addr,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [2:0]        slot,
  output logic              stall,
  output logic              done
`ifdef MULTI_SEQ_XFER_COUNT_EN
  ,output logic [3:0]       xfer_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST = 3'(SLOTS - 1);

  state_t     state, state_nx;
  logic [2:0] slot_nx;
  logic [6:0] mask, mask_nx;
  logic       all_en, all_en_nx;
  logic       is_store, is_store_nx;
  logic       multi_op, accept, slot_en;

  // Opcodes 11xx: bit1 selects the all-slot variants, bit0 selects stores.
  assign multi_op = (instr_mem_4[3:2] == 2'b11);
  assign accept   = (state == IDLE) && op_valid && multi_op;
  assign slot_en  = all_en || mask[LAST - slot];

  assign rf_rd_addr  = slot;
  assign rf_wr_addr  = slot;
  assign rf_wr_data  = data_from_mem_16;
  assign mem_wr_data = reg_read_16;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot     <= '0;
      mask     <= '0;
      all_en   <= 1'b0;
      is_store <= 1'b0;
    end else begin
      state    <= state_nx;
      slot     <= slot_nx;
      mask     <= mask_nx;
      all_en   <= all_en_nx;
      is_store <= is_store_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    slot_nx     = slot;
    mask_nx     = mask;
    all_en_nx   = all_en;
    is_store_nx = is_store;
    rf_wr_en    = 1'b0;
    mem_wr_en   = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall       = 1'b1;
          mask_nx     = immediate_7;
          all_en_nx   = instr_mem_4[1];
          is_store_nx = instr_mem_4[0];
          slot_nx     = '0;
          state_nx    = RUN;
        end
      end
      RUN: begin
        rf_wr_en  = slot_en && !is_store;
        mem_wr_en = slot_en && is_store;
        stall     = (slot < LAST);
        // Empty masks still walk every slot so the address generator stays aligned.
        if (slot == LAST) begin
          slot_nx  = '0;
          state_nx = DONE;
        end else begin
          slot_nx  = slot + 3'd1;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MULTI_SEQ_XFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                     xfer_count <= '0;
    else if (accept)                xfer_count <= '0;
    else if (rf_wr_en || mem_wr_en) xfer_count <= xfer_count + 4'd1;
  end
`endif

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Bench for multi_reg_sequencer: table of instructions run back-to-back, scoreboard for per-slot transfers,
// plus reset, ignored-opcode and mid-RUN reset sequences.
module tb_multi_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, op_valid;
  logic [3:0]  instr_mem_4;
  logic [6:0]  immediate_7;
  logic [15:0] data_from_mem_16, reg_read_16;
  logic [2:0]  rf_rd_addr, rf_wr_addr, slot;
  logic        rf_wr_en, mem_wr_en, stall, done;
  logic [15:0] rf_wr_data, mem_wr_data;
`ifdef MULTI_SEQ_XFER_COUNT_EN
  logic [3:0]  xfer_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [6:0] mask;
    logic [6:0] exp_slots;  // bit s = slot s transfers
    logic       exp_store;
    int         exp_cnt;
    bit         noise;      // extra op_valid in cycles 3 and 8
  } vec_t;

  typedef struct {
    logic        store;
    logic [2:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  vec_t tbl[7];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [2:0] a);
    return 16'h1000 + {13'd0, a};
  endfunction

  function automatic logic [15:0] rf_val(input logic [2:0] a);
    return 16'hA500 ^ {a, a, a, a, 4'h0};
  endfunction

  // Memory and register-file models answer the DUT's current address.
  assign data_from_mem_16 = mem_val(slot);
  assign reg_read_16      = rf_val(rf_rd_addr);

  multi_reg_sequencer #(.DATA_W(16), .SLOTS(7)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .instr_mem_4(instr_mem_4),
    .immediate_7(immediate_7), .data_from_mem_16(data_from_mem_16), .reg_read_16(reg_read_16),
    .rf_rd_addr(rf_rd_addr), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .slot(slot), .stall(stall), .done(done)
`ifdef MULTI_SEQ_XFER_COUNT_EN
    ,.xfer_count(xfer_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every strobe must match the next expected transfer.
  always @(negedge clk) begin
    if (rf_wr_en || mem_wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got rf %b mem %b slot %0d, expected no strobe at %0t",
                 rf_wr_en, mem_wr_en, slot, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_both_strobes", {31'd0, rf_wr_en & mem_wr_en}, 32'd0);
        chk("sb_kind", {31'd0, mem_wr_en}, {31'd0, mon_e.store});
        chk("sb_addr", {29'd0, rf_wr_addr}, {29'd0, mon_e.addr});
        chk("sb_data", {16'd0, mon_e.store ? mem_wr_data : rf_wr_data}, {16'd0, mon_e.data});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    ev_t e;
    @(posedge clk); #1;
    op_valid = 1'b1; instr_mem_4 = v.op; immediate_7 = v.mask;
    #1;
    chk("c0_stall", stall, 1);
    chk("c0_rf_wr_en", rf_wr_en, 0);
    chk("c0_done", done, 0);
    for (int s = 0; s < 7; s++) begin
      if (v.exp_slots[s]) begin
        e.store = v.exp_store;
        e.addr  = 3'(s);
        e.data  = v.exp_store ? rf_val(3'(s)) : mem_val(3'(s));
        sb.push_back(e);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      op_valid    = v.noise && (c == 3 || c == 8);
      instr_mem_4 = v.noise ? 4'b1110 : v.op;
      immediate_7 = 7'($urandom);
      #1;
      if (c <= 7) begin
        chk("run_slot", slot, c - 1);
        chk("run_rd_addr", rf_rd_addr, c - 1);
        chk("run_wr_addr", rf_wr_addr, c - 1);
        chk("run_stall", stall, (c < 7) ? 1 : 0);
        chk("run_done", done, 0);
        chk("run_rf_wr_en", rf_wr_en, (v.exp_slots[c-1] && !v.exp_store) ? 1 : 0);
        chk("run_mem_wr_en", mem_wr_en, (v.exp_slots[c-1] && v.exp_store) ? 1 : 0);
      end else begin
        chk("c8_done", done, 1);
        chk("c8_stall", stall, 0);
        chk("c8_rf_wr_en", rf_wr_en, 0);
        chk("c8_mem_wr_en", mem_wr_en, 0);
        chk("c8_slot", slot, 0);
        chk("c8_sb_empty", sb.size(), 0);
`ifdef MULTI_SEQ_XFER_COUNT_EN
        chk("c8_xfer_count", xfer_count, v.exp_cnt);
`endif
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_slot"}, slot, 0);
    chk({tag, "_rf_wr_en"}, rf_wr_en, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    //            op       mask        exp_slots   st    cnt noise
    tbl[0] = '{4'b1110, 7'b0000000, 7'b1111111, 1'b0, 7, 1'b0};  // LA ignores mask
    tbl[1] = '{4'b1100, 7'b1010101, 7'b1010101, 1'b0, 4, 1'b1};  // LM sparse
    tbl[2] = '{4'b1101, 7'b0000001, 7'b1000000, 1'b1, 1, 1'b0};  // SM, slot 6 only
    tbl[3] = '{4'b1111, 7'b0010000, 7'b1111111, 1'b1, 7, 1'b1};  // SA full
    tbl[4] = '{4'b1100, 7'b0000000, 7'b0000000, 1'b0, 0, 1'b0};  // LM empty mask
    tbl[5] = '{4'b1101, 7'b1100000, 7'b0000011, 1'b1, 2, 1'b0};  // SM slots 0,1
    tbl[6] = '{4'b1100, 7'b1111111, 7'b1111111, 1'b0, 7, 1'b0};  // LM full

    rst_n = 1'b0; op_valid = 1'b0; instr_mem_4 = 4'b0000; immediate_7 = 7'd0;
    repeat (3) @(posedge clk);
    #2;
    chk_idle("rst");
    chk("rst_rd_addr", rf_rd_addr, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
`ifdef MULTI_SEQ_XFER_COUNT_EN
    chk("rst_xfer_count", xfer_count, 0);
`endif
    rst_n = 1'b1;

    // Non-multi opcode: no stall, no state change.
    @(posedge clk); #1;
    op_valid = 1'b1; instr_mem_4 = 4'b0110; immediate_7 = 7'h7F;
    #1;
    chk("bad_op_stall", stall, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      chk_idle("bad_op");
    end

    // Table runs back-to-back: each new instruction lands in cycle 9 of the previous.
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Reset in the middle of an LA: slots 0..3 transfer, then nothing.
    @(posedge clk); #1;
    op_valid = 1'b1; instr_mem_4 = 4'b1110; immediate_7 = 7'd0;
    for (int s = 0; s < 4; s++) begin
      mon_e.store = 1'b0; mon_e.addr = 3'(s); mon_e.data = mem_val(3'(s));
      sb.push_back(mon_e);
    end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    #1;
    chk("midrst_slot3", slot, 3);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk_idle("midrst");
`ifdef MULTI_SEQ_XFER_COUNT_EN
    chk("midrst_xfer_count", xfer_count, 0);
`endif
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      chk("post_rst_done", done, 0);
      chk("post_rst_stall", stall, 0);
    end
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_reg_sequencer.md
# multi_reg_sequencer

Register-file-side sequencer for multi-word memory instructions: LM (1100), SM (1101), LA (1110) and SA (1111). It sits in the mem stage beside the address generator. Its 3-bit slot counter runs in lockstep with the generator's `k` counter. Each slot, it steers one word between data memory and the register file:
- for loads, it issues the register write;
- for stores, it issues the register read and the memory write.

It also holds a stall on the earlier pipeline stages and pulses `done` when the transfer completes.

## Interface
Parameters:
- `DATA_W`, 16, data word width
- `SLOTS`, 7, slots per instruction; slot s maps to register Rs

Ports:
- `clk` input 1: clock, rising edge
- `rst_n` input 1: synchronous, active-low reset
- `op_valid` input 1: instruction in mem stage is valid
- `instr_mem_4` input 4: mem-stage `instr[15:12]`
- `immediate_7` input 7: mem-stage `instr[6:0]`, the register mask; bit `6-s` selects slot s
- `data_from_mem_16` input DATA_W: read data for the current slot's address, valid in the same cycle
- `reg_read_16` input DATA_W: register-file read data for `rf_rd_addr`, same cycle
- `rf_rd_addr` output 3: register to read, equals current slot (stores)
- `rf_wr_en` output 1: register-file write strobe (loads)
- `rf_wr_addr` output 3: register to write, equals current slot
- `rf_wr_data` output DATA_W: equals `data_from_mem_16`
- `mem_wr_en` output 1: data-memory write strobe (stores)
- `mem_wr_data` output DATA_W: equals `reg_read_16`
- `slot` output 3: current slot index
- `stall` output 1: freeze fetch, decode and execute
- `done` output 1: one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: when `op_valid` is high and the opcode is one of 1100, 1101, 1110 or 1111, latch the opcode and mask, clear `slot`, and go to RUN.
  - RUN: one slot per cycle. At `slot == SLOTS-1`, go to DONE.
  - DONE: assert `done`, then go to IDLE.
- All other opcodes are ignored. `op_valid` is ignored outside IDLE.
- Slot enable:
  - LA/SA: every slot is enabled.
  - LM/SM: slot s is enabled only when the latched mask bit `[6-s]` is 1.
- Strobes in RUN on an enabled slot (combinational from the state registers):
  - LM/LA: `rf_wr_en = 1`.
  - SM/SA: `mem_wr_en = 1`.
- Address outputs:
  - `rf_wr_addr = rf_rd_addr = slot` at all times.
  - In IDLE and DONE, both strobes are 0.
- An all-zero mask still runs all 7 slots with no strobes, to keep lockstep with the address generator.
- `slot` wraps from 6 to 0 on the exit from RUN. It never takes the value 7.
- `stall` = (IDLE ∧ `op_valid` ∧ multi-opcode) ∨ (RUN ∧ `slot` < 6).

## Timing
- Reset (`rst_n = 0` at a clock edge) puts the FSM in IDLE with `slot = 0`. The latched opcode and mask are cleared.
- Output values after reset:
  - `rf_wr_en`, `mem_wr_en`, `done`, `stall` = 0 (`stall` stays 0 unless `op_valid` with a multi-opcode is presented).
  - `slot`, `rf_rd_addr`, `rf_wr_addr` = 0.
- Reset mid-RUN aborts the transfer. No further strobes are issued and `done` is not pulsed.
- Cycle numbering, with the instruction accepted in cycle 0:
  - cycle 0: `stall = 1`;
  - cycles 1–7: RUN slots 0–6; `stall` is 1 through cycle 6 and 0 in cycle 7;
  - cycle 8: `done = 1`;
  - cycle 9: IDLE, and a new instruction may be accepted.
- Latency from acceptance to `done` is 8 cycles. Back-to-back instructions are therefore spaced at least 9 cycles apart.
- The mask is latched in cycle 0, so changes on `immediate_7` during RUN have no effect.

## Configuration
- `MULTI_SEQ_XFER_COUNT_EN`
  - Defined: adds output `xfer_count` (4 bits).
    - Cleared on acceptance.
    - Increments on every cycle with `rf_wr_en` or `mem_wr_en` high.
    - Holds its value after `done` until the next acceptance.
    - Reset value is 0.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **LA full sweep:** opcode 1110, `data_from_mem_16 = 16'h1000 + slot`. Expect `rf_wr_en = 1` in cycles 1–7, writing R0 = 1000 through R6 = 1006, and `done` in cycle 8.
- **LM sparse mask:** opcode 1100, mask 7'b1010101. Expect writes only at slots 0, 2, 4, 6 and none at slots 1, 3, 5; `xfer_count = 4` when the macro is defined.
- **SM mask / SA full:** SM with mask 7'b0000001 gives exactly one `mem_wr_en`, at slot 6, with `mem_wr_data = reg_read_16`. SA gives 7 memory writes.
- **Stall and back-to-back:**
  - `stall` is 1 in cycles 0–6 and 0 in cycle 7.
  - A second `op_valid` in cycles 3 and 8 is ignored.
  - A second `op_valid` in cycle 9 is accepted.
- **Edge cases:** opcode 0110 with `op_valid` causes no state change and no stall. An all-zero LM mask completes in 8 cycles with zero strobes.
- **Reset mid-RUN:** `rst_n = 0` at slot 3. On the next cycle the FSM is IDLE, `slot = 0`, all strobes and `stall` are 0, and `done` never asserts.
